// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter with clear, load, wrap/saturate mode,
// a registered wrap pulse and a saturating count of wrap events.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8,
    parameter bit SAT_MODE      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     n_rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [NUM_CNT_BITS-1:0]  load_val_i,
    input  logic                     count_enable_i,
    input  logic                     count_up_i,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val_i,
    output logic [NUM_CNT_BITS-1:0]  count_out_o,
    output logic                     rollover_flag_o,
    output logic                     wrap_pulse_o,
    output logic [NUM_WRAP_BITS-1:0] wrap_count_o
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0]  count_q, count_d;
    logic                     pulse_q, pulse_d;
    logic [NUM_WRAP_BITS-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                     up_terminal;
    logic                     down_terminal;
    logic                     wrap_event;

    assign up_terminal   = (count_q >= rollover_val_i);
    assign down_terminal = (count_q <= CNT_ONE);

    // Terminal is tested before re-ranging so that rollover_val 0/1 in down
    // mode is treated as a terminal reload rather than a silent re-range.
    always_comb begin
        count_d    = count_q;
        wrap_event = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_enable_i) begin
            if (count_up_i) begin
                if (!up_terminal) begin
                    count_d = count_q + CNT_ONE;
                end else if (!SAT_MODE) begin
                    count_d    = CNT_ONE;
                    wrap_event = 1'b1;
                end
            end else begin
                if (down_terminal) begin
                    if (!SAT_MODE) begin
                        count_d    = rollover_val_i;
                        wrap_event = 1'b1;
                    end
                end else if (count_q > rollover_val_i) begin
                    count_d = rollover_val_i;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        pulse_d    = wrap_event;
        wrap_cnt_d = wrap_cnt_q;
        if (clear_i) begin
            wrap_cnt_d = '0;
        end else if (wrap_event && !(&wrap_cnt_q)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            count_q    <= '0;
            pulse_q    <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign count_out_o     = count_q;
    assign rollover_flag_o = count_up_i ? up_terminal : down_terminal;
    assign wrap_pulse_o    = pulse_q;
    assign wrap_count_o    = wrap_cnt_q;

endmodule
